// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared definitions for the DAC output stage: FSM state
//                encoding, default geometry and the saturation-limit helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dac_pkg;

  // Default geometry; the top-level parameters pick these up.
  localparam int c_in_w_default     = 24;
  localparam int c_out_w_default    = 16;
  localparam int c_channels_default = 2;
  localparam int c_sclk_div_default = 2;

  // Frame-processing FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_SAT   = 2'd2,
    ST_SHIFT = 2'd3
  } dac_state_e;

  // Signed limit of a w-bit two's-complement word: neg=1 gives -2^(w-1),
  // neg=0 gives 2^(w-1)-1. Used as an elaboration-time constant.
  function automatic longint sat_limit(input int unsigned w, input logic neg);
    longint mag;
    mag = longint'(1) <<< (w - 1);
    return neg ? -mag : mag - 1;
  endfunction

endpackage : dac_pkg
`default_nettype wire

// File: rtl/sample_saturator.sv
`default_nettype none
// ============================================================================
//  Module      : sample_saturator
//  Description : One channel of the DAC datapath. Registers the arithmetic
//                right-shifted sample when i_scale_en is high, then clamps
//                the registered value into the OUT_W signed range and applies
//                the optional offset-binary MSB inversion (combinational).
//  Ports       : i_clk, i_reset (async, active low), i_scale_en,
//                i_sample (signed IN_W), i_shift (0..7), i_offset_binary,
//                o_word (OUT_W), o_clip (value had to be clamped)
//  Revision    : 1.0  initial release
// ============================================================================
module sample_saturator
  import dac_pkg::*;
#(
  parameter int IN_W  = c_in_w_default,
  parameter int OUT_W = c_out_w_default
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_scale_en,
  input  logic signed [IN_W-1:0] i_sample,
  input  logic [2:0]             i_shift,
  input  logic                   i_offset_binary,
  output logic [OUT_W-1:0]       o_word,
  output logic                   o_clip
);

  // Compare in a width that holds both the input and the output range, so
  // the clamp is correct even if IN_W is not wider than OUT_W.
  localparam int c_ext_w = (IN_W > OUT_W) ? IN_W : OUT_W;

  localparam logic signed [c_ext_w-1:0] c_max_ext = c_ext_w'(sat_limit(OUT_W, 1'b0));
  localparam logic signed [c_ext_w-1:0] c_min_ext = c_ext_w'(sat_limit(OUT_W, 1'b1));
  localparam logic [OUT_W-1:0] c_max_word = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_min_word = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]    scaled_q;
  logic signed [c_ext_w-1:0] w_ext;
  logic [OUT_W-1:0]          w_sat;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      scaled_q <= '0;
    end else if (i_scale_en) begin
      scaled_q <= i_sample >>> i_shift;   // signed operand: sign bits fill in
    end
  end

  assign w_ext = c_ext_w'(scaled_q);

  always_comb begin
    w_sat  = w_ext[OUT_W-1:0];
    o_clip = 1'b0;
    if (w_ext > c_max_ext) begin
      w_sat  = c_max_word;
      o_clip = 1'b1;
    end else if (w_ext < c_min_ext) begin
      w_sat  = c_min_word;
      o_clip = 1'b1;
    end
  end

  // Offset binary is two's complement with the MSB flipped.
  assign o_word = {w_sat[OUT_W-1] ^ i_offset_binary, w_sat[OUT_W-2:0]};

endmodule : sample_saturator
`default_nettype wire

// File: rtl/dac_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dac_output_stage
//  Description : Accepts a multi-channel sample frame, scales, saturates and
//                optionally offsets each channel, presents the parallel
//                words, and serialises them MSB first (channel 0 first) with
//                a generated serial clock and a one-bit-wide frame sync.
//  Ports       : i_clk, i_reset (async, active low)
//                i_sample_valid / o_sample_ready  frame handshake
//                i_sample, i_shift, i_offset_binary  frame data + controls
//                i_clip_clear                     clears sticky o_clip
//                o_word, o_word_valid, o_clip     parallel result
//                o_dac_sclk, o_dac_fsync, o_dac_sdata  serial DAC pins
//  Revision    : 1.0  initial release
// ============================================================================
module dac_output_stage
  import dac_pkg::*;
#(
  parameter int IN_W     = c_in_w_default,
  parameter int OUT_W    = c_out_w_default,
  parameter int CHANNELS = c_channels_default,
  parameter int SCLK_DIV = c_sclk_div_default
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_sample_valid,
  output logic                      o_sample_ready,
  input  logic [CHANNELS*IN_W-1:0]  i_sample,
  input  logic [2:0]                i_shift,
  input  logic                      i_offset_binary,
  input  logic                      i_clip_clear,
  output logic [CHANNELS*OUT_W-1:0] o_word,
  output logic                      o_word_valid,
  output logic                      o_clip,
  output logic                      o_dac_sclk,
  output logic                      o_dac_fsync,
  output logic                      o_dac_sdata
);

  localparam int c_nbits = CHANNELS * OUT_W;
  localparam int c_bit_w = $clog2(c_nbits);
  localparam int c_div_w = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_nbits - 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCLK_DIV - 1);

  dac_state_e state_q, state_d;

  logic [CHANNELS*IN_W-1:0]  sample_q;
  logic [2:0]                shift_q;
  logic                      offset_q;
  logic [CHANNELS*OUT_W-1:0] word_q;
  logic                      word_valid_q;
  logic                      clip_q;
  logic [c_nbits-1:0]        sreg_q, sreg_d;
  logic [c_bit_w-1:0]        bit_q, bit_d;
  logic [c_div_w-1:0]        div_q, div_d;
  logic                      sclk_q, sclk_d;

  logic [CHANNELS*OUT_W-1:0] w_word;
  logic [CHANNELS-1:0]       w_clip;
  logic [c_nbits-1:0]        w_ser;
  logic                      w_accept;
  logic                      w_fall;
  logic                      w_last_bit;

  assign w_accept   = i_sample_valid && (state_q == ST_IDLE);
  // A falling sclk edge is where the next bit is launched.
  assign w_fall     = (state_q == ST_SHIFT) && (div_q == c_div_last) && sclk_q;
  assign w_last_bit = w_fall && (bit_q == c_bit_last);

  // --------------------------------------------------------------------------
  // Per-channel datapath; the serial image is reordered so channel 0 leaves
  // first from the MSB end of the shift register.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sample_saturator #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_sat (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_scale_en      (state_q == ST_SCALE),
      .i_sample        (sample_q[c*IN_W +: IN_W]),
      .i_shift         (shift_q),
      .i_offset_binary (offset_q),
      .o_word          (w_word[c*OUT_W +: OUT_W]),
      .o_clip          (w_clip[c])
    );
    assign w_ser[(CHANNELS-1-c)*OUT_W +: OUT_W] = w_word[c*OUT_W +: OUT_W];
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_accept) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_SAT;
      ST_SAT:   state_d = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Serial pins are gated so they read 0 outside SHIFT.
  always_comb begin
    o_sample_ready = 1'b0;
    o_dac_sclk     = 1'b0;
    o_dac_fsync    = 1'b0;
    o_dac_sdata    = 1'b0;
    case (state_q)
      ST_IDLE: o_sample_ready = 1'b1;
      ST_SHIFT: begin
        o_dac_sclk  = sclk_q;
        o_dac_fsync = (bit_q == '0);
        o_dac_sdata = sreg_q[c_nbits-1];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serializer next state: sclk toggles every SCLK_DIV clocks starting low;
  // data shifts only when sclk falls, so it is stable at every rising edge.
  // --------------------------------------------------------------------------
  always_comb begin
    sreg_d = '0;
    bit_d  = '0;
    div_d  = '0;
    sclk_d = 1'b0;
    if (state_q == ST_SAT) begin
      sreg_d = w_ser;
    end else if (state_q == ST_SHIFT) begin
      sreg_d = sreg_q;
      bit_d  = bit_q;
      sclk_d = sclk_q;
      if (div_q == c_div_last) begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          sreg_d = sreg_q << 1;
          bit_d  = bit_q + c_bit_w'(1);
        end
      end else begin
        div_d = div_q + c_div_w'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sreg_q <= '0;
      bit_q  <= '0;
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      bit_q  <= bit_d;
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame capture and parallel result. The clip set term is checked first so
  // a simultaneous clear cannot hide a new clip event.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sample_q     <= '0;
      shift_q      <= '0;
      offset_q     <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      if (w_accept) begin
        sample_q <= i_sample;
        shift_q  <= i_shift;
        offset_q <= i_offset_binary;
      end
      word_valid_q <= (state_q == ST_SAT);
      if (state_q == ST_SAT) begin
        word_q <= w_word;
      end
      if ((state_q == ST_SAT) && (|w_clip)) begin
        clip_q <= 1'b1;
      end else if (i_clip_clear) begin
        clip_q <= 1'b0;
      end
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;
  assign o_clip       = clip_q;

endmodule : dac_output_stage
`default_nettype wire

// File: tb/tb_dac_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_output_stage
//  Description : Directed self-checking bench for dac_output_stage
//                (IN_W=24, OUT_W=16, CHANNELS=2, SCLK_DIV=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_output_stage;

  localparam int IN_W     = 24;
  localparam int OUT_W    = 16;
  localparam int CHANNELS = 2;
  localparam int SCLK_DIV = 2;

  logic                      i_clk = 1'b0;
  logic                      i_reset = 1'b0;
  logic                      i_sample_valid = 1'b0;
  logic                      o_sample_ready;
  logic [CHANNELS*IN_W-1:0]  i_sample = '0;
  logic [2:0]                i_shift = '0;
  logic                      i_offset_binary = 1'b0;
  logic                      i_clip_clear = 1'b0;
  logic [CHANNELS*OUT_W-1:0] o_word;
  logic                      o_word_valid;
  logic                      o_clip;
  logic                      o_dac_sclk;
  logic                      o_dac_fsync;
  logic                      o_dac_sdata;

  int n_cmp = 0;
  int n_err = 0;

  dac_output_stage #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .CHANNELS (CHANNELS),
    .SCLK_DIV (SCLK_DIV)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_sample_valid  (i_sample_valid),
    .o_sample_ready  (o_sample_ready),
    .i_sample        (i_sample),
    .i_shift         (i_shift),
    .i_offset_binary (i_offset_binary),
    .i_clip_clear    (i_clip_clear),
    .o_word          (o_word),
    .o_word_valid    (o_word_valid),
    .o_clip          (o_clip),
    .o_dac_sclk      (o_dac_sclk),
    .o_dac_fsync     (o_dac_fsync),
    .o_dac_sdata     (o_dac_sdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step one clock; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!o_sample_ready && n < 400) begin
      tick();
      n++;
    end
    if (!o_sample_ready) check_eq({tag, "_ready_timeout"}, 64'(o_sample_ready), 64'd1);
  endtask

  // Offers one frame, then scrambles the inputs so a late capture would be
  // visible. Returns on the cycle o_word_valid is expected (accept + 2).
  task automatic send_frame(input logic [23:0] c0, input logic [23:0] c1,
                            input logic [2:0] sh, input logic off, input string tag);
    wait_ready(tag);
    i_sample        = {c1, c0};
    i_shift         = sh;
    i_offset_binary = off;
    i_sample_valid  = 1'b1;
    tick();
    i_sample_valid  = 1'b0;
    i_sample        = {24'h7FFFFF, 24'h800000};
    i_shift         = 3'd0;
    i_offset_binary = ~off;
    check_eq({tag, "_ready_busy"}, 64'(o_sample_ready), 64'd0);
    tick();
    check_eq({tag, "_vld_early"}, 64'(o_word_valid), 64'd0);
    tick();
    check_eq({tag, "_vld"}, 64'(o_word_valid), 64'd1);
  endtask

  // Watches the 128 SHIFT cycles of one frame starting at its first cycle.
  task automatic run_serial(input logic [31:0] exp_bits, input string tag);
    logic [31:0] bits;
    logic        prev_sclk;
    logic        prev_sdata;
    int rises, fs, fs_early, busy, bad_edge;
    bits = '0; prev_sclk = 1'b0; prev_sdata = o_dac_sdata;
    rises = 0; fs = 0; fs_early = 0; busy = 0; bad_edge = 0;
    for (int i = 0; i < 128; i++) begin
      if (o_dac_sclk && !prev_sclk) begin
        bits = {bits[30:0], o_dac_sdata};
        rises++;
      end
      if (o_dac_fsync) begin
        fs++;
        if (i < 4) fs_early++;
      end
      if (!o_sample_ready) busy++;
      // Data may only move together with a falling sclk.
      if (i > 0 && (o_dac_sdata != prev_sdata) && !(prev_sclk && !o_dac_sclk)) bad_edge++;
      prev_sclk  = o_dac_sclk;
      prev_sdata = o_dac_sdata;
      tick();
    end
    check_eq({tag, "_bits"},     64'(bits),      64'(exp_bits));
    check_eq({tag, "_rises"},    64'(rises),     64'd32);
    check_eq({tag, "_fsync"},    64'(fs),        64'd4);
    check_eq({tag, "_fs_first"}, 64'(fs_early),  64'd4);
    check_eq({tag, "_busy"},     64'(busy),      64'd128);
    check_eq({tag, "_sd_edge"},  64'(bad_edge),  64'd0);
    check_eq({tag, "_idle"},     64'(o_sample_ready), 64'd1);
    check_eq({tag, "_sclk_lo"},  64'(o_dac_sclk), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[3];
    int n_acc, rises, vpulses, busy_rdy, busy_vld, activity;
    logic prev_sclk;
    logic drop_next;

    // ---------------- reset state
    repeat (3) tick();
    check_eq("rst_ready", 64'(o_sample_ready), 64'd1);
    check_eq("rst_word",  64'(o_word),         64'd0);
    check_eq("rst_vld",   64'(o_word_valid),   64'd0);
    check_eq("rst_clip",  64'(o_clip),         64'd0);
    check_eq("rst_pins",  64'({o_dac_sclk, o_dac_fsync, o_dac_sdata}), 64'd0);
    i_reset = 1'b1;
    tick();

    // ---------------- scaling: 0x001000 >>> 3 = 0x0200, offset -> 0x8200; ch1 0 -> 0x8000
    send_frame(24'h001000, 24'h000000, 3'd3, 1'b1, "scale");
    check_eq("scale_word", 64'(o_word), 64'h8000_8200);
    check_eq("scale_clip", 64'(o_clip), 64'd0);
    run_serial(32'h8200_8000, "scale_ser");

    // ---------------- saturation, with clear held high as the clip occurs (set wins)
    i_clip_clear = 1'b1;
    send_frame(24'h7FFFFF, 24'h800000, 3'd3, 1'b1, "sat");
    check_eq("sat_word", 64'(o_word), 64'h0000_FFFF);
    check_eq("sat_clip_setwins", 64'(o_clip), 64'd1);
    i_clip_clear = 1'b0;
    run_serial(32'hFFFF_0000, "sat_ser");
    check_eq("sat_clip_sticky", 64'(o_clip), 64'd1);
    i_clip_clear = 1'b1;
    tick();
    i_clip_clear = 1'b0;
    check_eq("sat_clip_clear", 64'(o_clip), 64'd0);

    // ---------------- serial frame: 0x0ABC00 >>> 7 = 0x1578; 0xFF8000 >>> 7 = 0xFF00
    send_frame(24'h0ABC00, 24'hFF8000, 3'd7, 1'b0, "ser");
    check_eq("ser_word", 64'(o_word), 64'hFF00_1578);
    check_eq("ser_fsync0", 64'(o_dac_fsync), 64'd1);
    run_serial(32'h1578_FF00, "ser_ser");

    // ---------------- back-to-back with valid held high
    i_sample = {24'h000000, 24'h001000};
    i_shift = 3'd3;
    i_offset_binary = 1'b0;
    i_sample_valid = 1'b1;
    n_acc = 0; rises = 0; vpulses = 0; prev_sclk = 1'b0; drop_next = 1'b0;
    for (int cyc = 0; cyc < 410; cyc++) begin
      if (drop_next) begin
        i_sample_valid = 1'b0;
        drop_next = 1'b0;
      end
      if (i_sample_valid && o_sample_ready && n_acc < 3) begin
        acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) drop_next = 1'b1;
      end
      if (o_dac_sclk && !prev_sclk) rises++;
      if (o_word_valid) vpulses++;
      prev_sclk = o_dac_sclk;
      tick();
    end
    i_sample_valid = 1'b0;
    check_eq("b2b_count", 64'(n_acc), 64'd3);
    if (n_acc == 3) begin
      check_eq("b2b_gap1", 64'(acc[1] - acc[0]), 64'd131);
      check_eq("b2b_gap2", 64'(acc[2] - acc[1]), 64'd131);
    end
    check_eq("b2b_rises", 64'(rises), 64'd96);
    check_eq("b2b_vpulses", 64'(vpulses), 64'd3);

    // ---------------- busy then reset at bit 10 (ch1 0x7FFFFF clips)
    send_frame(24'h0ABC00, 24'h7FFFFF, 3'd7, 1'b0, "busy");
    check_eq("busy_clip", 64'(o_clip), 64'd1);
    i_sample = {24'h000100, 24'h000200};
    i_sample_valid = 1'b1;
    busy_rdy = 0; busy_vld = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_sample_ready) busy_rdy++;
      if (o_word_valid) busy_vld++;
    end
    check_eq("busy_no_ready", 64'(busy_rdy), 64'd0);
    check_eq("busy_no_accept", 64'(busy_vld), 64'd0);
    i_sample_valid = 1'b0;
    i_reset = 1'b0;
    #1;
    check_eq("mrst_ready", 64'(o_sample_ready), 64'd1);
    check_eq("mrst_word",  64'(o_word),         64'd0);
    check_eq("mrst_vld",   64'(o_word_valid),   64'd0);
    check_eq("mrst_clip",  64'(o_clip),         64'd0);
    check_eq("mrst_pins",  64'({o_dac_sclk, o_dac_fsync, o_dac_sdata}), 64'd0);
    tick();
    tick();
    i_reset = 1'b1;
    activity = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_dac_sclk || o_dac_fsync || o_dac_sdata || o_word_valid || !o_sample_ready) activity++;
    end
    check_eq("post_rst_quiet", 64'(activity), 64'd0);
    send_frame(24'h0ABC00, 24'hFF8000, 3'd7, 1'b0, "restart");
    check_eq("restart_fsync0", 64'(o_dac_fsync), 64'd1);
    run_serial(32'h1578_FF00, "restart_ser");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dac_output_stage
`default_nettype wire
